// File: rtl/line_buffer_scheduler.sv
// line_buffer_scheduler
//   Sequences a bank of four 1-row line buffers as a rotating 3x3-window source.
//   One buffer takes the incoming pixel row while the other three are read in lockstep.
//   Optional feature macro: LBS_IRQ_EN adds a sticky frame-done interrupt (irq / irq_clr).
//
// Handshake: a pixel transfers on a rising clock edge where in_valid and in_ready are
// both high (accept = in_valid & in_ready). in_ready is derived from scheduler state
// only and never from in_valid. The source may raise or drop in_valid at any cycle.
// There is no output handshake: a READ burst runs ROW_SIZE consecutive cycles, and the
// line buffers' data is qualified one cycle later by win_valid/win_sel.
module line_buffer_scheduler #(
  parameter int ROW_SIZE = 512,
  parameter int NUM_ROWS = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] lb_wr_en,
  output logic [3:0] lb_rd_en,
  output logic [1:0] win_sel,
  output logic       win_valid,
  output logic       frame_done,
`ifdef LBS_IRQ_EN
  output logic       irq,
  input  logic       irq_clr,
`endif
  output logic [1:0] state_dbg
);

  localparam int PW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam logic [PW-1:0] PIX_LAST      = PW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] ROWS_FULL     = RW'(NUM_ROWS);
  localparam logic [RW-1:0] ROWS_LAST_WIN = RW'(NUM_ROWS - 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_pix, rd_pix;
  logic [1:0]    wr_buf, rd_buf, rd_buf1, rd_buf2;
  logic [RW-1:0] wr_rows, rd_rows;
  logic [2:0]    rows_avail;
  logic          accept, row_wr_done, row_rd_done, frame_clear;

  // A full bank (4 unconsumed rows) or a fully written frame blocks the source.
  assign in_ready    = (rows_avail != 3'd4) && (wr_rows != ROWS_FULL);
  assign accept      = in_valid & in_ready;
  assign row_wr_done = accept && (wr_pix == PIX_LAST);
  assign row_rd_done = (state == READ) && (rd_pix == PIX_LAST);
  assign frame_clear = (state == DONE);
  assign frame_done  = (state == DONE);
  assign state_dbg   = state;
  assign rd_buf1     = rd_buf + 2'd1;
  assign rd_buf2     = rd_buf + 2'd2;

  // Write-side enable and the three window-buffer read enables.
  always_comb begin
    lb_wr_en = 4'b0000;
    lb_rd_en = 4'b0000;
    if (accept) begin
      lb_wr_en = 4'b0001 << wr_buf;
    end
    if (state == READ) begin
      lb_rd_en[rd_buf]  = 1'b1;
      lb_rd_en[rd_buf1] = 1'b1;
      lb_rd_en[rd_buf2] = 1'b1;
    end
  end

  // Write position: pixel within row, target buffer, rows written this frame.
  always_ff @(posedge clk) begin
    if (rst || frame_clear) begin
      wr_pix  <= '0;
      wr_buf  <= 2'd0;
      wr_rows <= '0;
    end else if (accept) begin
      if (row_wr_done) begin
        wr_pix  <= '0;
        wr_buf  <= wr_buf + 2'd1;
        wr_rows <= wr_rows + RW'(1);
      end else begin
        wr_pix <= wr_pix + PW'(1);
      end
    end
  end

  // Completed rows not yet consumed by a read burst.
  always_ff @(posedge clk) begin
    if (rst || frame_clear) begin
      rows_avail <= 3'd0;
    end else begin
      case ({row_wr_done, row_rd_done})
        2'b10:   rows_avail <= rows_avail + 3'd1;
        2'b01:   rows_avail <= rows_avail - 3'd1;
        default: rows_avail <= rows_avail;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a burst starts once three rows are available; the frame
  // ends after the last window row (NUM_ROWS-2 windows per frame).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rows_avail >= 3'd3) state_nxt = READ;
      READ: if (row_rd_done) state_nxt = (rd_rows == ROWS_LAST_WIN) ? DONE : IDLE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read position: pixel within burst, top-row buffer, window rows read.
  always_ff @(posedge clk) begin
    if (rst || frame_clear) begin
      rd_pix  <= '0;
      rd_buf  <= 2'd0;
      rd_rows <= '0;
    end else if (state != READ) begin
      rd_pix <= '0;
    end else if (row_rd_done) begin
      rd_pix  <= '0;
      rd_buf  <= rd_buf + 2'd1;
      rd_rows <= rd_rows + RW'(1);
    end else begin
      rd_pix <= rd_pix + PW'(1);
    end
  end

  // Window qualifiers aligned with the line buffers' one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_sel   <= 2'd0;
      win_valid <= 1'b0;
    end else begin
      win_sel   <= rd_buf;
      win_valid <= (state == READ);
    end
  end

`ifdef LBS_IRQ_EN
  // Sticky frame-done interrupt; a new frame_done beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (frame_done) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

  // A buffer belonging to the current window is never written.
  a_no_overwrite: assert property (@(posedge clk) disable iff (rst) (lb_wr_en & lb_rd_en) == 4'b0000);

endmodule
